dec_entry: RTL and testbench
============================

DEC_ENTRY -- requirements
Module: dec_entry

Interface
REQ-001 The block SHALL have parameter MAX_DIGITS, default 3, giving the maximum number of significant decimal digits accepted per entry.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state SHALL update on posedge clk.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset sampled on posedge clk.
REQ-004 The block SHALL have port digit_valid, input, 1, a one-cycle strobe (already synchronised, debounced and edge-detected) qualifying digit.
REQ-005 The block SHALL have port digit, input, 4, the unsigned BCD digit value; it is valid only when digit_valid=1.
REQ-006 The block SHALL have port neg_toggle, input, 1, a one-cycle strobe that toggles the sign of the entry.
REQ-007 The block SHALL have port clear, input, 1, a one-cycle strobe that discards the entry.
REQ-008 The block SHALL have port enter, input, 1, a one-cycle strobe that commits the entry.
REQ-009 The block SHALL have port value, output, 8, the current entry as two's complement, for driving the signed decimal display.
REQ-010 The block SHALL have port active, output, 1, high while an entry is in progress.
REQ-011 The block SHALL have port result, output, 8, the last committed two's complement value, held until the next commit.
REQ-012 The block SHALL have port result_valid, output, 1, a one-cycle pulse marking a new result.
REQ-013 The block SHALL have port err, output, 1, a one-cycle pulse marking a rejected strobe.

Function
REQ-014 The block SHALL hold the state bits mag (8-bit unsigned, 0..128), neg (1 bit) and cnt (significant-digit count, 0..MAX_DIGITS), plus an FSM with states IDLE and ENTRY.
REQ-015 value SHALL equal neg ? (~mag + 1) : mag, truncated to 8 bits, with combinational output from registered state.
REQ-016 active SHALL be 1 exactly in ENTRY.
REQ-017 At most one strobe SHALL be processed per cycle, with priority clear > enter > neg_toggle > digit_valid; lower-priority strobes in the same cycle SHALL be dropped without err.
REQ-018 A digit strobe with digit > 9 SHALL be rejected: state unchanged, err=1 next cycle.
REQ-019 A digit strobe with digit <= 9 SHALL compute new = mag*10 + digit at a width of at least 11 bits, with limit = neg ? 128 : 127.
REQ-020 If new > limit, or if cnt = MAX_DIGITS and new != 0, the digit strobe SHALL be rejected with err and state unchanged.
REQ-021 An accepted digit strobe SHALL set mag = new, go to ENTRY, and increment cnt only when new != 0, so leading zeros are not counted.
REQ-022 neg_toggle SHALL invert neg and go to ENTRY, except that when neg=1 and mag=128 it SHALL be rejected with err, since +128 is not representable.
REQ-023 neg=1 with mag=0 SHALL be legal; value is 0x00 and subsequent digits build a negative number.
REQ-024 enter in ENTRY SHALL load result = value and assert result_valid for exactly one cycle (the cycle after the strobe), and SHALL return to IDLE with mag=0, neg=0, cnt=0.
REQ-025 enter in IDLE SHALL be ignored: no result_valid and no err.
REQ-026 clear SHALL return to IDLE with mag=0, neg=0, cnt=0; result SHALL be unchanged and no err SHALL be raised.
REQ-027 All outputs SHALL reflect a strobe one cycle after the strobe edge (latency 1).
REQ-028 err and result_valid SHALL never be asserted in the same cycle.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL enter IDLE with mag=0, neg=0, cnt=0, value=0x00, active=0, result=0x00, result_valid=0, err=0.
REQ-030 rst SHALL override all strobes in the same cycle, and reset mid-entry SHALL discard the entry without a result_valid pulse.

Verification
REQ-031 Digits 1,2,7 then enter SHALL give value 0x01, 0x0C, 0x7F; then result=0x7F with a one-cycle result_valid; then value=0x00 and active=0.
REQ-032 neg_toggle then digits 1,2,8 SHALL give value 0xFF, 0xF4, 0x80; a further digit 0 and a further neg_toggle SHALL each give err with value staying 0x80.
REQ-033 Positive digits 1,2,8 SHALL reject the third digit with err and leave value=0x0C; digits 0,0,5 SHALL give value=0x05 with cnt=1.
REQ-034 digit=4'hA SHALL give err with no state change; enter while IDLE SHALL produce neither result_valid nor err.
REQ-035 clear and digit_valid (digit 7) in the same cycle mid-entry SHALL give value=0x00, active=0, no err, and result unchanged.
REQ-036 rst asserted after digits 4,2 SHALL give all outputs at reset values the next cycle, with no result_valid pulse.

Source files
------------

// File: rtl/dec_entry.sv
// ---------------------------------------------------------------------------
// dec_entry
// Signed decimal keypad entry. Digits are accumulated into an unsigned
// magnitude with a separate sign flag; the two's complement view of the entry
// is presented on `value` for the display, and `enter` commits it to `result`.
// Out-of-range digits and sign flips that would leave the 8-bit
// two's complement range are rejected with a one-cycle `err` pulse.
//
// Ports
//   clk          : system clock, all state updates on posedge
//   rst          : synchronous active-high reset
//   digit_valid  : one-cycle strobe qualifying `digit`
//   digit        : BCD digit value (values > 9 are rejected)
//   neg_toggle   : one-cycle strobe, flips the sign of the entry
//   clear        : one-cycle strobe, discards the entry
//   enter        : one-cycle strobe, commits the entry
//   value        : current entry as two's complement
//   active       : high while an entry is in progress
//   result       : last committed value, held until the next commit
//   result_valid : one-cycle pulse marking a new result
//   err          : one-cycle pulse marking a rejected strobe
// ---------------------------------------------------------------------------
module dec_entry #(
    parameter int MAX_DIGITS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       neg_toggle,
    input  logic       clear,
    input  logic       enter,
    output logic [7:0] value,
    output logic       active,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       err
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic {
        IDLE,
        ENTRY
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    mag_q, mag_d;
    logic          neg_q, neg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    result_q, result_d;
    logic          result_valid_q, result_valid_d;
    logic          err_q, err_d;

    // 11 bits hold the worst case 128*10 + 9 without wrapping.
    logic [10:0]   new_mag;
    logic [10:0]   limit;

    // Negative entries may reach 128 (-128); positive ones stop at 127.
    assign new_mag = ({3'b000, mag_q} * 11'd10) + {7'b0000000, digit};
    assign limit   = neg_q ? 11'd128 : 11'd127;

    always_comb begin
        // NOTE: every _d gets a default before any branch so no path can
        // leave it unassigned and infer a latch.
        state_d        = state_q;
        mag_d          = mag_q;
        neg_d          = neg_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        err_d          = 1'b0;

        // Strobe priority: clear > enter > neg_toggle > digit_valid.
        // Lower-priority strobes in the same cycle are silently dropped.
        if (clear) begin
            state_d = IDLE;
            mag_d   = 8'd0;
            neg_d   = 1'b0;
            cnt_d   = '0;
        end else if (enter) begin
            if (state_q == ENTRY) begin
                result_d       = value;
                result_valid_d = 1'b1;
                state_d        = IDLE;
                mag_d          = 8'd0;
                neg_d          = 1'b0;
                cnt_d          = '0;
            end
        end else if (neg_toggle) begin
            // -128 has no positive counterpart in 8-bit two's complement.
            if (neg_q && (mag_q == 8'd128)) begin
                err_d = 1'b1;
            end else begin
                neg_d   = ~neg_q;
                state_d = ENTRY;
            end
        end else if (digit_valid) begin
            if (digit > 4'd9) begin
                err_d = 1'b1;
            end else if ((new_mag > limit) ||
                         ((cnt_q == CW'(MAX_DIGITS)) && (new_mag != 11'd0))) begin
                err_d = 1'b1;
            end else begin
                mag_d   = new_mag[7:0];
                state_d = ENTRY;
                // Leading zeros do not consume a significant-digit slot.
                if (new_mag != 11'd0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q        <= IDLE;
            mag_q          <= 8'd0;
            neg_q          <= 1'b0;
            cnt_q          <= '0;
            result_q       <= 8'd0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            mag_q          <= mag_d;
            neg_q          <= neg_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
        end
    end

    assign value        = neg_q ? (~mag_q + 8'd1) : mag_q;
    assign active       = (state_q == ENTRY);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;

endmodule

// File: tb/tb_dec_entry.sv
// ---------------------------------------------------------------------------
// tb_dec_entry
// Two instances (MAX_DIGITS = 3 and MAX_DIGITS = 2) share one stimulus.
// A behavioural model tracks each instance and is compared on every falling
// edge; directed sequences add literal expectations on the first instance.
// ---------------------------------------------------------------------------
module tb_dec_entry;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       digit_valid;
    logic [3:0] digit;
    logic       neg_toggle;
    logic       clear;
    logic       enter;

    logic [7:0] value_w  [2];
    logic [7:0] result_w [2];
    logic       active_w [2];
    logic       rv_w     [2];
    logic       err_w    [2];

    dec_entry dut0 (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
        .neg_toggle(neg_toggle), .clear(clear), .enter(enter),
        .value(value_w[0]), .active(active_w[0]), .result(result_w[0]),
        .result_valid(rv_w[0]), .err(err_w[0])
    );

    dec_entry #(.MAX_DIGITS(2)) dut1 (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
        .neg_toggle(neg_toggle), .clear(clear), .enter(enter),
        .value(value_w[1]), .active(active_w[1]), .result(result_w[1]),
        .result_valid(rv_w[1]), .err(err_w[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int mag;
        int cnt;
        bit neg;
        bit act;
        bit rv;
        bit err;
        int res;
    } mstate_t;

    mstate_t m [2];
    bit      started = 1'b0;

    function automatic logic [7:0] enc(input int mag, input bit neg);
        int v;
        v = neg ? -mag : mag;
        return v[7:0];
    endfunction

    function automatic mstate_t next_m(input mstate_t s, input int max_d);
        mstate_t n;
        int nv;
        n     = s;
        n.rv  = 1'b0;
        n.err = 1'b0;
        if (rst) begin
            n = '{mag: 0, cnt: 0, neg: 1'b0, act: 1'b0, rv: 1'b0, err: 1'b0, res: 0};
        end else if (clear) begin
            n.mag = 0; n.cnt = 0; n.neg = 1'b0; n.act = 1'b0;
        end else if (enter) begin
            if (s.act) begin
                n.res = int'(enc(s.mag, s.neg));
                n.rv  = 1'b1;
                n.mag = 0; n.cnt = 0; n.neg = 1'b0; n.act = 1'b0;
            end
        end else if (neg_toggle) begin
            if (s.neg && s.mag == 128) n.err = 1'b1;
            else begin
                n.neg = !s.neg;
                n.act = 1'b1;
            end
        end else if (digit_valid) begin
            if (int'(digit) > 9) n.err = 1'b1;
            else begin
                nv = s.mag * 10 + int'(digit);
                if (nv > (s.neg ? 128 : 127) || (s.cnt == max_d && nv != 0)) n.err = 1'b1;
                else begin
                    n.mag = nv;
                    n.act = 1'b1;
                    if (nv != 0) n.cnt = s.cnt + 1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m[0]    <= next_m(m[0], 3);
        m[1]    <= next_m(m[1], 2);
        started <= 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("value[%0d]", k),  value_w[k],  enc(m[k].mag, m[k].neg));
                check($sformatf("active[%0d]", k), active_w[k], m[k].act);
                check($sformatf("result[%0d]", k), result_w[k], m[k].res[7:0]);
                check($sformatf("rv[%0d]", k),     rv_w[k],     m[k].rv);
                check($sformatf("err[%0d]", k),    err_w[k],    m[k].err);
                check($sformatf("rv_err_excl[%0d]", k), rv_w[k] & err_w[k], 1'b0);
            end
            check("cnt[0]", dut0.cnt_q, m[0].cnt);
            check("cnt[1]", dut1.cnt_q, m[1].cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input bit r, input bit c, input bit e, input bit n,
                         input bit dv, input logic [3:0] d);
        rst = r; clear = c; enter = e; neg_toggle = n; digit_valid = dv; digit = d;
        @(posedge clk);
        #1;
        rst = 1'b0; clear = 1'b0; enter = 1'b0; neg_toggle = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    endtask

    task automatic key(input logic [3:0] d);
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic expect0(input string tag, input logic [7:0] v, input bit a,
                           input logic [7:0] r, input bit rv, input bit e);
        check({tag, ".value"},  value_w[0],  v);
        check({tag, ".active"}, active_w[0], a);
        check({tag, ".result"}, result_w[0], r);
        check({tag, ".rv"},     rv_w[0],     rv);
        check({tag, ".err"},    err_w[0],    e);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; enter = 1'b0; neg_toggle = 1'b0;
        digit_valid = 1'b0; digit = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect0("reset", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Positive entry up to the positive limit, then commit.
        key(4'd1); expect0("p1",   8'h01, 1'b1, 8'h00, 1'b0, 1'b0);
        key(4'd2); expect0("p12",  8'h0C, 1'b1, 8'h00, 1'b0, 1'b0);
        key(4'd7); expect0("p127", 8'h7F, 1'b1, 8'h00, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        expect0("enter127", 8'h00, 1'b0, 8'h7F, 1'b1, 1'b0);
        @(posedge clk); #1;
        expect0("hold127", 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0);

        // Negative entry down to -128, then rejected digit and sign flip.
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        expect0("neg0", 8'h00, 1'b1, 8'h7F, 1'b0, 1'b0);
        key(4'd1); expect0("n1",   8'hFF, 1'b1, 8'h7F, 1'b0, 1'b0);
        key(4'd2); expect0("n12",  8'hF4, 1'b1, 8'h7F, 1'b0, 1'b0);
        key(4'd8); expect0("n128", 8'h80, 1'b1, 8'h7F, 1'b0, 1'b0);
        key(4'd0); expect0("n1280", 8'h80, 1'b1, 8'h7F, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        expect0("flip128", 8'h80, 1'b1, 8'h7F, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        expect0("clr", 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0);

        // Positive 128 rejected; leading zeros not counted.
        key(4'd1); key(4'd2); key(4'd8);
        expect0("p128", 8'h0C, 1'b1, 8'h7F, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        key(4'd0); key(4'd0); key(4'd5);
        expect0("lz005", 8'h05, 1'b1, 8'h7F, 1'b0, 1'b0);
        check("lz005.cnt", dut0.cnt_q, 32'd1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // Digit-count limit binds only on the two-digit instance.
        key(4'd1); key(4'd2); key(4'd0);
        check("cap.value0", value_w[0], 8'h78);
        check("cap.err0",   err_w[0],   1'b0);
        check("cap.value1", value_w[1], 8'h0C);
        check("cap.err1",   err_w[1],   1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // Illegal BCD and enter while idle.
        key(4'hA); expect0("bcdA", 8'h00, 1'b0, 8'h7F, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        expect0("idle_enter", 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0);

        // Clear wins over a same-cycle digit.
        key(4'd3); expect0("p3", 8'h03, 1'b1, 8'h7F, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7);
        expect0("clr_dig", 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0);

        // Negative commit.
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        key(4'd5);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        expect0("enter_m5", 8'h00, 1'b0, 8'hFB, 1'b1, 1'b0);

        // Reset mid-entry overrides a simultaneous enter.
        key(4'd4); key(4'd2);
        expect0("p42", 8'h2A, 1'b1, 8'hFB, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        expect0("rst_mid", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Randomised strobes, overlapping to exercise priority.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 63) == 0);
            clear       = ($urandom_range(0, 15) == 0);
            enter       = ($urandom_range(0, 9) == 0);
            neg_toggle  = ($urandom_range(0, 7) == 0);
            digit_valid = ($urandom_range(0, 1) == 0);
            digit       = 4'($urandom_range(0, 11));
            @(posedge clk);
            #1;
        end
        rst = 1'b0; clear = 1'b0; enter = 1'b0; neg_toggle = 1'b0;
        digit_valid = 1'b0; digit = 4'd0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
